afifo_wptr_ctrl: RTL and testbench
==================================

Name: afifo_wptr_ctrl

Overview:
Write-side pointer controller for the async FIFO.
- Sequences writes into the dual-port FIFO memory: generates write address and write enable.
- Produces the Gray-coded write pointer handed to the read-domain 2-flop synchronizer.
- Consumes the read pointer after it has been synchronized into this domain, and derives the full flag and ready handshake.

Parameters:
- ADDR_SIZE, 2: memory address width. Depth = 2^ADDR_SIZE. Pointer width PW = ADDR_SIZE+1, which is 3 bits at the default and matches the synchronizer default width.
- AF_THRESH, 3: almost-full level threshold. Used only with AFIFO_WLEVEL_EN.

Ports:
- sclk, input, 1: write-domain clock.
- srst, input, 1: asynchronous, active-low reset.
- wr_valid, input, 1: producer has a word to write.
- wr_ready, output, 1: FIFO can accept a word. Equal to ~full.
- mem_we, output, 1: memory write enable.
- mem_waddr, output, ADDR_SIZE: memory write address.
- wptr_gray, output, PW: registered Gray write pointer, sent to the read-domain synchronizer.
- rptr_gray_sync, input, PW: read Gray pointer after synchronization into sclk.
- full, output, 1: FIFO full, registered.
- wr_level, output, PW: occupancy as seen by the writer. Present only with AFIFO_WLEVEL_EN.
- almost_full, output, 1: level threshold flag. Present only with AFIFO_WLEVEL_EN.

Behaviour:
- Reset: srst low clears wptr_bin, wptr_gray, full, wr_level and almost_full to 0 immediately, with no clock needed. Deassertion is taken on a sclk edge.
- Handshake and push: push = wr_valid & wr_ready. wr_ready = ~full.
- Memory strobes: mem_we = push (combinational). mem_waddr = wptr_bin[ADDR_SIZE-1:0], i.e. the current, pre-increment address.
- Pointer update: wptr_bin_nxt = wptr_bin + push, modulo 2^PW, so wrap-around is natural. Gray form: wgray_nxt = wptr_bin_nxt ^ (wptr_bin_nxt >> 1).
- Registers: wptr_bin and wptr_gray are registered every cycle. wptr_gray must come straight from a flop, with no glitching logic between the flop and the CDC.
- Full: full_nxt = (wgray_nxt == {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]}). full is registered.
  - full rises in the cycle after the push that fills the FIFO.
  - full falls in the cycle after rptr_gray_sync advances.
- Stall: wr_valid held while full causes no mem_we and no pointer change. The producer waits and no data is lost.
- Simultaneous events: a read-pointer advance and a push in the same cycle are evaluated together through wgray_nxt against the current sync pointer. This gives a conservative full and never overflows.
- Pessimism: full may stay asserted up to 2 sclk cycles longer than true occupancy because of synchronizer latency. This is allowed; a false not-full is never allowed.
- rptr_gray_sync is treated as valid Gray code; the block does no extra checking on it.

Optional Feature:
Macro: AFIFO_WLEVEL_EN.
- Defined:
  - rbin = Gray-to-binary of rptr_gray_sync.
  - wr_level registered = wptr_bin_nxt - rbin, modulo 2^PW, range 0..2^ADDR_SIZE.
  - almost_full registered = (level_nxt >= AF_THRESH).
  - Both reset to 0.
- Undefined: wr_level and almost_full ports and their logic are absent. Port list and behaviour otherwise identical.

Test Plan:
- Reset: hold srst low mid-clock with wr_valid=1 → wptr_gray=000, full=0, mem_waddr=0 immediately. No mem_we while in reset.
- Fill, with rptr_gray_sync=000: 4 back-to-back pushes → mem_waddr 0,1,2,3. wptr_gray sequence 001,011,010,110. full=1 the cycle after the 4th push. wr_ready=0.
- Stall: keep wr_valid=1 for 5 cycles while full → mem_we=0 throughout, wptr_gray stays 110, full stays 1.
- Drain and refill: set rptr_gray_sync=001 → full=0 next cycle. One push → mem_waddr=0, wptr_gray=111, full=1 again.
- Wrap: 8 pushes with rptr_gray_sync tracking 2 cycles behind → wptr_gray returns to 000. Address wraps 3→0. full never set while occupancy < 4.
- AFIFO_WLEVEL_EN, AF_THRESH=3, rptr_gray_sync=000: 3 pushes → wr_level 1,2,3. almost_full=1 after the 3rd push. After the 4th push, wr_level=4 and full=1.

Source files
------------

// File: rtl/afifo_wptr_ctrl.sv
// afifo_wptr_ctrl: write-side pointer controller for an async FIFO.
// Generates memory write strobes, the registered Gray write pointer handed
// to the read-domain synchronizer, and the registered full flag derived from
// the read pointer synchronized into sclk.
// Optional build macro AFIFO_WLEVEL_EN adds the wr_level / almost_full outputs.
// Handshake: a word is transferred (push) in any cycle where wr_valid and
// wr_ready are both high at the rising sclk edge; wr_valid may be held while
// wr_ready is low and nothing happens until wr_ready returns.
module afifo_wptr_ctrl #(
    parameter int ADDR_SIZE = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                 sclk,
    input  logic                 srst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [ADDR_SIZE:0]   wptr_gray,
    input  logic [ADDR_SIZE:0]   rptr_gray_sync,
    output logic                 full
`ifdef AFIFO_WLEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 almost_full
`endif
);

    localparam int PW = ADDR_SIZE + 1;
    // Gray "full" pattern: read pointer with its two MSBs inverted.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_bin_nxt;
    logic [PW-1:0] wgray_nxt;
    logic          full_nxt;
    logic          push;

    // Handshake and memory strobes; the push is also blocked while in reset.
    always_comb begin
        wr_ready  = ~full;
        push      = wr_valid & wr_ready & srst;
        mem_we    = push;
        mem_waddr = wptr_bin[ADDR_SIZE-1:0];
    end

    // Next binary / Gray pointer and full comparison against the synced read pointer.
    always_comb begin
        wptr_bin_nxt = wptr_bin + {{ADDR_SIZE{1'b0}}, push};
        wgray_nxt    = wptr_bin_nxt ^ (wptr_bin_nxt >> 1);
        full_nxt     = (wgray_nxt == (rptr_gray_sync ^ FULL_MASK));
    end

    // Pointer and full registers; wptr_gray leaves the block straight from a flop.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
        end else begin
            wptr_bin  <= wptr_bin_nxt;
            wptr_gray <= wgray_nxt;
            full      <= full_nxt;
        end
    end

`ifdef AFIFO_WLEVEL_EN
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] level_nxt;

    // Gray-to-binary of the synced read pointer and the writer-side occupancy.
    always_comb begin
        rbin[PW-1] = rptr_gray_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_gray_sync[i];
        end
        level_nxt = wptr_bin_nxt - rbin;
    end

    // Registered occupancy and almost-full flag.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            wr_level    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_level    <= level_nxt;
            almost_full <= (level_nxt >= AF_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_afifo_wptr_ctrl.sv
// tb_afifo_wptr_ctrl: directed + randomized bench for afifo_wptr_ctrl.
// Reference model counts pushes and reads as plain integers; occupancy is
// their difference, full means occupancy equals the depth.
module tb_afifo_wptr_ctrl;

    localparam int ADDR_SIZE = 2;
    localparam int AF_THRESH = 3;
    localparam int PW        = ADDR_SIZE + 1;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    logic                 sclk;
    logic                 srst;
    logic                 wr_valid;
    logic                 wr_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_waddr;
    logic [PW-1:0]        wptr_gray;
    logic [PW-1:0]        rptr_gray_sync;
    logic                 full;
`ifdef AFIFO_WLEVEL_EN
    logic [PW-1:0]        wr_level;
    logic                 almost_full;
`endif

    int n_checks;
    int n_pass;

    // model state
    int   m_wcnt;
    int   m_rcnt;
    logic m_full;
    int   wprev1;
    int   wprev2;

    afifo_wptr_ctrl #(.ADDR_SIZE(ADDR_SIZE), .AF_THRESH(AF_THRESH)) dut (
        .sclk           (sclk),
        .srst           (srst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .wptr_gray      (wptr_gray),
        .rptr_gray_sync (rptr_gray_sync),
        .full           (full)
`ifdef AFIFO_WLEVEL_EN
        ,
        .wr_level       (wr_level),
        .almost_full    (almost_full)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic void model_clear();
        m_wcnt = 0;
        m_rcnt = 0;
        m_full = 1'b0;
        wprev1 = 0;
        wprev2 = 0;
    endfunction

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic cycle(input logic v);
        logic exp_push;
        int   occ;
        wr_valid       = v;
        rptr_gray_sync = to_gray(m_rcnt);
        @(negedge sclk);
        exp_push = v & ~m_full;
        n_checks++;
        if (mem_we !== exp_push)
            $display("FAIL mem_we: got %b expected %b (t=%0t)", mem_we, exp_push, $time);
        else n_pass++;
        n_checks++;
        if (wr_ready !== ~m_full)
            $display("FAIL wr_ready: got %b expected %b (t=%0t)", wr_ready, ~m_full, $time);
        else n_pass++;
        n_checks++;
        if (mem_waddr !== ADDR_SIZE'(m_wcnt % DEPTH))
            $display("FAIL mem_waddr: got %0d expected %0d (t=%0t)", mem_waddr, m_wcnt % DEPTH, $time);
        else n_pass++;
        @(posedge sclk);
        if (exp_push) m_wcnt++;
        occ    = m_wcnt - m_rcnt;
        m_full = (occ == DEPTH);
        wprev2 = wprev1;
        wprev1 = m_wcnt;
        #1;
        n_checks++;
        if (wptr_gray !== to_gray(m_wcnt))
            $display("FAIL wptr_gray: got %b expected %b (t=%0t)", wptr_gray, to_gray(m_wcnt), $time);
        else n_pass++;
        n_checks++;
        if (full !== m_full)
            $display("FAIL full: got %b expected %b (t=%0t)", full, m_full, $time);
        else n_pass++;
`ifdef AFIFO_WLEVEL_EN
        n_checks++;
        if (wr_level !== PW'(occ))
            $display("FAIL wr_level: got %0d expected %0d (t=%0t)", wr_level, occ, $time);
        else n_pass++;
        n_checks++;
        if (almost_full !== (occ >= AF_THRESH))
            $display("FAIL almost_full: got %b expected %b (t=%0t)", almost_full, occ >= AF_THRESH, $time);
        else n_pass++;
`endif
    endtask

    // Reset asserted mid-clock with wr_valid high; outputs must clear at once.
    task automatic test_reset();
        wr_valid = 1'b1;
        @(negedge sclk);
        #2;
        srst = 1'b0;
        #1;
        n_checks++;
        if (wptr_gray !== 3'b000) $display("FAIL reset_wptr_gray: got %b expected 000", wptr_gray);
        else n_pass++;
        n_checks++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full);
        else n_pass++;
        n_checks++;
        if (mem_waddr !== '0) $display("FAIL reset_waddr: got %0d expected 0", mem_waddr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge sclk);
            #1;
            n_checks++;
            if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we);
            else n_pass++;
            n_checks++;
            if (wptr_gray !== 3'b000) $display("FAIL reset_hold_gray: got %b expected 000", wptr_gray);
            else n_pass++;
        end
        srst = 1'b1;
        model_clear();
    endtask

    task automatic test_fill();
        logic [PW-1:0] tbl [4];
        tbl[0] = 3'b001; tbl[1] = 3'b011; tbl[2] = 3'b010; tbl[3] = 3'b110;
        m_rcnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1);
            n_checks++;
            if (wptr_gray !== tbl[i]) $display("FAIL fill_gray%0d: got %b expected %b", i, wptr_gray, tbl[i]);
            else n_pass++;
        end
        n_checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL fill_full: got full=%b ready=%b expected full=1 ready=0", full, wr_ready);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) cycle(1'b1);
        n_checks++;
        if (wptr_gray !== 3'b110 || full !== 1'b1)
            $display("FAIL stall_hold: got gray=%b full=%b expected gray=110 full=1", wptr_gray, full);
        else n_pass++;
    endtask

    task automatic test_drain_refill();
        m_rcnt = 1;
        cycle(1'b0);
        n_checks++;
        if (full !== 1'b0) $display("FAIL drain_full: got %b expected 0", full);
        else n_pass++;
        cycle(1'b1);
        n_checks++;
        if (wptr_gray !== 3'b111 || full !== 1'b1)
            $display("FAIL refill: got gray=%b full=%b expected gray=111 full=1", wptr_gray, full);
        else n_pass++;
    endtask

    // Reads follow writes two cycles late; the pointer wraps all the way round.
    task automatic test_wrap();
        int guard;
        int saw_full;
        test_reset();
        guard    = 0;
        saw_full = 0;
        while (m_wcnt < 8 && guard < 40) begin
            m_rcnt = wprev2;
            cycle(1'b1);
            if (full === 1'b1) saw_full++;
            guard++;
        end
        n_checks++;
        if (m_wcnt != 8) $display("FAIL wrap_timeout: got %0d pushes expected 8", m_wcnt);
        else n_pass++;
        n_checks++;
        if (wptr_gray !== 3'b000) $display("FAIL wrap_gray: got %b expected 000", wptr_gray);
        else n_pass++;
        n_checks++;
        if (saw_full != 0) $display("FAIL wrap_full: got %0d full cycles expected 0", saw_full);
        else n_pass++;
    endtask

    task automatic test_random();
        logic v;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && m_rcnt < wprev2) m_rcnt++;
            v = ($urandom_range(0, 3) != 0);
            cycle(v);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        srst           = 1'b0;
        wr_valid       = 1'b0;
        rptr_gray_sync = '0;
        model_clear();
        repeat (2) @(posedge sclk);
        #1;
        srst = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        test_reset();
        test_fill();
        test_stall();
        test_drain_refill();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
